// File: rtl/stack_pkg.sv
// Shared types and constants for the operand stack and its backing RAM.
package stack_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 256;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_ADDR,
      RD_DATA,
      ACK
   } stack_state_t;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/stack_ram.sv
// Single-port synchronous-read RAM, read-first: a write cycle returns the old word.
module stack_ram
   import stack_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [ptr_w(DEPTH)-1:0]   addr,
   input  logic [WIDTH-1:0]          wdata,
   output logic [WIDTH-1:0]          rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: the array has no reset so it maps onto block RAM; contents are
   // only meaningful below the stack pointer anyway.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments give read-first ordering: rdata
      // takes the word stored before this edge's write.
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata <= mem_q[addr];
   end

endmodule

// File: rtl/operand_stack.sv
// LIFO operand stack served over a trigger/done handshake, backed by stack_ram.
module operand_stack
   import stack_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    trigger,
   input  logic                    push,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic                    done,
   output logic [ptr_w(DEPTH):0]   count,
   output logic                    empty,
   output logic                    full,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam logic [PTR_W:0]   SP_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   SP_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   stack_state_t     state_q;
   logic [PTR_W:0]   sp_q;
   logic             trigger_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] rdata_q;
   logic             done_q;
   logic             overflow_q;
   logic             underflow_q;

   logic             req;
   logic             ram_we;
   logic [PTR_W-1:0] ram_addr;
   logic [WIDTH-1:0] ram_rdata;

   assign req      = trigger & ~trigger_q;
   assign ram_we   = (state_q == WR);
   // Pops address the top entry, one below sp; pushes write at sp.
   assign ram_addr = (state_q == RD_ADDR) ? sp_q[PTR_W-1:0] - PTR_ONE
                                          : sp_q[PTR_W-1:0];

   stack_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sp_q        <= '0;
         trigger_q   <= 1'b0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         trigger_q <= trigger;
         done_q    <= (state_q == ACK);
         case (state_q)
            IDLE: begin
               if (req) begin
                  wdata_q <= wdata;
                  if (push) begin
                     if (sp_q == SP_FULL) begin
                        overflow_q <= 1'b1;
                        state_q    <= ACK;
                     end else begin
                        state_q <= WR;
                     end
                  end else if (sp_q == '0) begin
                     underflow_q <= 1'b1;
                     rdata_q     <= '0;
                     state_q     <= ACK;
                  end else begin
                     state_q <= RD_ADDR;
                  end
               end
            end
            WR: begin
               sp_q    <= sp_q + SP_ONE;
               state_q <= ACK;
            end
            RD_ADDR: begin
               sp_q    <= sp_q - SP_ONE;
               state_q <= RD_DATA;
            end
            RD_DATA: begin
               rdata_q <= ram_rdata;
               state_q <= ACK;
            end
            ACK: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rdata     = rdata_q;
   assign done      = done_q;
   assign count     = sp_q;
   assign empty     = (sp_q == '0);
   assign full      = (sp_q == SP_FULL);
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_operand_stack.sv
// Randomized bench for operand_stack against a queue-based LIFO reference model.
module tb_operand_stack;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int PTR_W = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst;
   logic             trigger;
   logic             push;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;
   logic             done;
   logic [PTR_W:0]   count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   operand_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .trigger   (trigger),
      .push      (push),
      .wdata     (wdata),
      .rdata     (rdata),
      .done      (done),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: the stack is a queue, flags are plain sticky bits.
   logic [WIDTH-1:0] model_q [$];
   logic             exp_ovf;
   logic             exp_unf;
   logic [WIDTH-1:0] exp_rdata;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag);
      check({tag, ".count"},     64'(count),     64'(model_q.size()));
      check({tag, ".empty"},     64'(empty),     64'(model_q.size() == 0));
      check({tag, ".full"},      64'(full),      64'(model_q.size() == DEPTH));
      check({tag, ".overflow"},  64'(overflow),  64'(exp_ovf));
      check({tag, ".underflow"}, 64'(underflow), 64'(exp_unf));
      check({tag, ".rdata"},     64'(rdata),     64'(exp_rdata));
   endtask

   task automatic model_reset();
      model_q.delete();
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
      exp_rdata = '0;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      trigger = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   // One request; glitch re-raises trigger mid-pop to prove busy edges are dropped.
   task automatic do_op(input string tag, input logic is_push,
                        input logic [WIDTH-1:0] data, input logic glitch);
      int  lat;
      int  n;
      logic seen;
      logic gl;
      if (is_push) begin
         if (model_q.size() == DEPTH) begin
            exp_ovf = 1'b1;
            lat     = 1;
         end else begin
            model_q.push_back(data);
            lat = 2;
         end
      end else begin
         if (model_q.size() == 0) begin
            exp_unf   = 1'b1;
            exp_rdata = '0;
            lat       = 1;
         end else begin
            exp_rdata = model_q.pop_back();
            lat       = 3;
         end
      end
      gl      = glitch && (lat == 3);
      trigger = 1'b1;
      push    = is_push;
      wdata   = data;
      n       = 0;
      seen    = 1'b0;
      while (!seen && n < 12) begin
         tick();
         n++;
         if (n == 1) begin
            trigger = 1'b0;
            push    = 1'($urandom);
            wdata   = $urandom;
         end
         if (gl && n == 2) trigger = 1'b1;
         if (gl && n == 3) trigger = 1'b0;
         seen = done;
      end
      check({tag, ".latency"}, 64'(n), 64'(lat + 1));
      check_status(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int dones;
      rst     = 1'b0;
      trigger = 1'b0;
      push    = 1'b0;
      wdata   = '0;
      do_reset();
      check("reset.done", 64'(done), 64'(0));
      check_status("reset");

      do_op("push5",   1'b1, 32'h0000_0005, 1'b0);
      do_op("pushFFE", 1'b1, 32'hFFFF_FFFE, 1'b0);
      do_op("pop1",    1'b0, '0, 1'b0);
      do_op("pop2",    1'b0, '0, 1'b0);
      do_op("pop_empty", 1'b0, '0, 1'b0);
      tick();
      check_status("unf_sticky");

      for (int i = 1; i <= 5; i++) do_op("fill", 1'b1, WIDTH'(i), 1'b0);
      for (int i = 0; i < 4; i++) do_op("drain", 1'b0, '0, 1'b0);

      // Trigger held high for six cycles is a single request.
      trigger = 1'b1;
      push    = 1'b1;
      wdata   = 32'h0000_002A;
      dones   = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 6) trigger = 1'b0;
         if (done) dones++;
      end
      model_q.push_back(32'h0000_002A);
      check("hold.dones", 64'(dones), 64'(1));
      check_status("hold");
      do_op("hold_pop", 1'b0, '0, 1'b0);

      do_op("ctl_push7", 1'b1, 32'd7, 1'b0);
      do_op("ctl_push3", 1'b1, 32'd3, 1'b0);
      do_op("ctl_pop3",  1'b0, '0, 1'b1);
      do_op("ctl_pop7",  1'b0, '0, 1'b0);

      // Reset lands at E1 of an accepted push: no done, stack empty.
      trigger = 1'b1;
      push    = 1'b1;
      wdata   = 32'h0000_0099;
      tick();
      rst     = 1'b1;
      trigger = 1'b0;
      tick();
      rst   = 1'b0;
      dones = 0;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) dones++;
      end
      check("rst_mid.dones", 64'(dones), 64'(0));
      check_status("rst_mid");

      for (int k = 0; k < 80; k++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) tick();
         do_op("rand", ($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
